// File: rtl/grab_bag_slot_ctrl.sv
// grab_bag_slot_ctrl
// Decides which of NUM_SLOTS sub-designs owns the shared digital outputs and
// analog pins, and sequences every hand-over break-before-make:
//   OFF -> BREAK (everything disconnected) -> RESET (new slot enabled, held in
//   reset) -> RUN (slot released, switches closed, output mux enabled).
// Every output is a flop whose D input is decoded from the next state and next
// cur_slot. The switch enables therefore change only on a clock edge and never
// glitch.

module grab_bag_slot_ctrl #(
    parameter int NUM_SLOTS    = 4,
    parameter int SEL_W        = 2,
    parameter int BREAK_CYCLES = 8,
    parameter int RESET_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [SEL_W-1:0]     sel_req,
    input  logic                 sel_strobe,
    output logic [NUM_SLOTS-1:0] slot_ena,
    output logic [NUM_SLOTS-1:0] slot_rst_n,
    output logic [NUM_SLOTS-1:0] ana_sw,
    output logic [SEL_W-1:0]     mux_sel,
    output logic                 mux_valid,
    output logic [SEL_W-1:0]     cur_slot,
    output logic                 busy
);

    // The down-counter must hold BREAK_CYCLES itself, because power-up loads it
    // with one extra dead cycle.
    localparam int CNT_MAX = (BREAK_CYCLES > RESET_CYCLES) ? BREAK_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BREAK = 2'd1;
    localparam logic [1:0] ST_RESET = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [SEL_W:0]     SLOT_LIMIT = (SEL_W + 1)'(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = {{(NUM_SLOTS - 1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic [SEL_W-1:0]     tgt_q, tgt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_SLOTS-1:0] slot_ena_q, slot_ena_d;
    logic [NUM_SLOTS-1:0] slot_rst_n_q, slot_rst_n_d;
    logic [NUM_SLOTS-1:0] ana_sw_q, ana_sw_d;
    logic                 mux_valid_q, mux_valid_d;
    logic                 busy_q, busy_d;

    logic                 req_valid;
    logic [NUM_SLOTS-1:0] slot_oh;

    // A request counts only while enabled and in range. It retargets the
    // pending slot in any state.
    assign req_valid = ena && sel_strobe && ({1'b0, sel_req} < SLOT_LIMIT);
    assign tgt_d     = req_valid ? sel_req : tgt_q;

    // Next-state logic for the hand-over sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case, so that no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;

        if (!ena) begin
            // Disable drops straight to OFF. Slot and target are kept, so the
            // same slot comes back when the design is enabled again.
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // On power-up the dead-time gets one extra cycle, because
                    // the pins have just left OFF.
                    state_d = ST_BREAK;
                    cnt_d   = CNT_W'(BREAK_CYCLES);
                end
                ST_BREAK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RESET;
                        cnt_d   = CNT_W'(RESET_CYCLES - 1);
                        cur_d   = tgt_d;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RESET: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if ((req_valid && (sel_req != cur_q)) || (tgt_q != cur_q)) begin
                        state_d = ST_BREAK;
                        cnt_d   = CNT_W'(BREAK_CYCLES - 1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign slot_oh = ONE_HOT0 << cur_d;

    // Output decode from the next state. The flops below make every output
    // change cleanly on the same edge as the state change.
    always_comb begin
        slot_ena_d   = '0;
        slot_rst_n_d = '0;
        ana_sw_d     = '0;
        mux_valid_d  = 1'b0;
        busy_d       = 1'b0;
        case (state_d)
            ST_BREAK: begin
                busy_d = 1'b1;
            end
            ST_RESET: begin
                slot_ena_d = slot_oh;
                busy_d     = 1'b1;
            end
            ST_RUN: begin
                slot_ena_d   = slot_oh;
                slot_rst_n_d = slot_oh;
                ana_sw_d     = slot_oh;
                mux_valid_d  = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs. Async reset returns to OFF with
    // everything disconnected.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here, so that all flops sample the
        // pre-edge values together.
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cur_q        <= '0;
            tgt_q        <= '0;
            cnt_q        <= '0;
            slot_ena_q   <= '0;
            slot_rst_n_q <= '0;
            ana_sw_q     <= '0;
            mux_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            slot_ena_q   <= slot_ena_d;
            slot_rst_n_q <= slot_rst_n_d;
            ana_sw_q     <= ana_sw_d;
            mux_valid_q  <= mux_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign slot_ena   = slot_ena_q;
    assign slot_rst_n = slot_rst_n_q;
    assign ana_sw     = ana_sw_q;
    assign mux_valid  = mux_valid_q;
    assign busy       = busy_q;
    assign cur_slot   = cur_q;
    assign mux_sel    = cur_q;

endmodule

// File: tb/tb_grab_bag_slot_ctrl.sv
// Directed-vector bench for grab_bag_slot_ctrl. There is one task per scenario,
// and each task holds its own inline comparisons. The default build is used for
// the main sequence. A NUM_SLOTS=3 build checks rejection of out-of-range
// requests.

module tb_grab_bag_slot_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] sel_req;
    logic       sel_strobe;
    logic [3:0] slot_ena, slot_rst_n, ana_sw;
    logic [1:0] mux_sel, cur_slot;
    logic       mux_valid, busy;

    logic [1:0] sel_req3;
    logic       sel_strobe3;
    logic [2:0] slot_ena3, slot_rst_n3, ana_sw3;
    logic [1:0] mux_sel3, cur_slot3;
    logic       mux_valid3, busy3;

    int n_pass  = 0;
    int n_total = 0;

    grab_bag_slot_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sel_req    (sel_req),
        .sel_strobe (sel_strobe),
        .slot_ena   (slot_ena),
        .slot_rst_n (slot_rst_n),
        .ana_sw     (ana_sw),
        .mux_sel    (mux_sel),
        .mux_valid  (mux_valid),
        .cur_slot   (cur_slot),
        .busy       (busy)
    );

    grab_bag_slot_ctrl #(.NUM_SLOTS(3), .SEL_W(2), .BREAK_CYCLES(8), .RESET_CYCLES(4)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sel_req    (sel_req3),
        .sel_strobe (sel_strobe3),
        .slot_ena   (slot_ena3),
        .slot_rst_n (slot_rst_n3),
        .ana_sw     (ana_sw3),
        .mux_sel    (mux_sel3),
        .mux_valid  (mux_valid3),
        .cur_slot   (cur_slot3),
        .busy       (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge. Sampling and driving happen 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Strobe a request, then run 12 more edges. A switch that is not
    // interrupted is back in RUN by then.
    task automatic do_switch(input logic [1:0] s);
        sel_req    = s;
        sel_strobe = 1'b1;
        tick();
        sel_strobe = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        int busy_cnt;
        rst_n       = 1'b0;
        ena         = 1'b1;
        sel_req     = 2'd0;
        sel_strobe  = 1'b0;
        sel_req3    = 2'd0;
        sel_strobe3 = 1'b0;
        tick();
        tick();
        n_total++; if (slot_ena !== 4'b0000) $display("FAIL reset_slot_ena got %b exp 0000", slot_ena); else n_pass++;
        n_total++; if (slot_rst_n !== 4'b0000) $display("FAIL reset_slot_rst_n got %b exp 0000", slot_rst_n); else n_pass++;
        n_total++; if (ana_sw !== 4'b0000) $display("FAIL reset_ana_sw got %b exp 0000", ana_sw); else n_pass++;
        n_total++; if (mux_valid !== 1'b0) $display("FAIL reset_mux_valid got %b exp 0", mux_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (cur_slot !== 2'd0) $display("FAIL reset_cur_slot got %0d exp 0", cur_slot); else n_pass++;
        n_total++; if (mux_sel !== 2'd0) $display("FAIL reset_mux_sel got %0d exp 0", mux_sel); else n_pass++;
        rst_n    = 1'b1;
        busy_cnt = 0;
        for (int m = 1; m <= 14; m++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (m == 9) begin
                n_total++; if (slot_ena !== 4'b0000) $display("FAIL pwrup_break_end slot_ena got %b exp 0000", slot_ena); else n_pass++;
            end
            if (m == 10) begin
                n_total++; if (slot_ena !== 4'b0001) $display("FAIL pwrup_reset slot_ena got %b exp 0001", slot_ena); else n_pass++;
                n_total++; if (slot_rst_n !== 4'b0000) $display("FAIL pwrup_reset slot_rst_n got %b exp 0000", slot_rst_n); else n_pass++;
            end
            if (m == 13) begin
                n_total++; if (mux_valid !== 1'b0) $display("FAIL pwrup_early mux_valid got %b exp 0", mux_valid); else n_pass++;
            end
        end
        n_total++; if (mux_valid !== 1'b1) $display("FAIL pwrup_run mux_valid got %b exp 1", mux_valid); else n_pass++;
        n_total++; if (slot_ena !== 4'b0001) $display("FAIL pwrup_run slot_ena got %b exp 0001", slot_ena); else n_pass++;
        n_total++; if (ana_sw !== 4'b0001) $display("FAIL pwrup_run ana_sw got %b exp 0001", ana_sw); else n_pass++;
        n_total++; if (slot_rst_n !== 4'b0001) $display("FAIL pwrup_run slot_rst_n got %b exp 0001", slot_rst_n); else n_pass++;
        n_total++; if (busy_cnt != 13) $display("FAIL pwrup_busy_cycles got %0d exp 13", busy_cnt); else n_pass++;
        n_total++; if (ana_sw3 !== 3'b001) $display("FAIL pwrup3_run ana_sw got %b exp 001", ana_sw3); else n_pass++;
    endtask

    task automatic test_out_of_range;
        sel_req3    = 2'd3;
        sel_strobe3 = 1'b1;
        tick();
        sel_strobe3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_total++; if (busy3 !== 1'b0) $display("FAIL oor_busy k=%0d got %b exp 0", k, busy3); else n_pass++;
            n_total++; if (ana_sw3 !== 3'b001) $display("FAIL oor_ana_sw k=%0d got %b exp 001", k, ana_sw3); else n_pass++;
            n_total++; if (cur_slot3 !== 2'd0) $display("FAIL oor_cur_slot k=%0d got %0d exp 0", k, cur_slot3); else n_pass++;
        end
        // The same build must still take an in-range request.
        sel_req3    = 2'd2;
        sel_strobe3 = 1'b1;
        tick();
        sel_strobe3 = 1'b0;
        n_total++; if (busy3 !== 1'b1) $display("FAIL inrange3_busy got %b exp 1", busy3); else n_pass++;
        n_total++; if (ana_sw3 !== 3'b000) $display("FAIL inrange3_ana_sw got %b exp 000", ana_sw3); else n_pass++;
    endtask

    task automatic test_switch;
        int busy_cnt;
        busy_cnt   = 0;
        sel_req    = 2'd2;
        sel_strobe = 1'b1;
        for (int m = 0; m <= 12; m++) begin
            tick();
            sel_strobe = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (m == 0) begin
                n_total++; if (ana_sw !== 4'b0000) $display("FAIL sw_break ana_sw got %b exp 0000", ana_sw); else n_pass++;
                n_total++; if (mux_valid !== 1'b0) $display("FAIL sw_break mux_valid got %b exp 0", mux_valid); else n_pass++;
                n_total++; if (slot_ena !== 4'b0000) $display("FAIL sw_break slot_ena got %b exp 0000", slot_ena); else n_pass++;
            end
            if (m == 7) begin
                n_total++; if (cur_slot !== 2'd0) $display("FAIL sw_break_end cur_slot got %0d exp 0", cur_slot); else n_pass++;
            end
            if (m == 8) begin
                n_total++; if (slot_ena !== 4'b0100) $display("FAIL sw_reset slot_ena got %b exp 0100", slot_ena); else n_pass++;
                n_total++; if (slot_rst_n !== 4'b0000) $display("FAIL sw_reset slot_rst_n got %b exp 0000", slot_rst_n); else n_pass++;
                n_total++; if (cur_slot !== 2'd2) $display("FAIL sw_reset cur_slot got %0d exp 2", cur_slot); else n_pass++;
            end
            if (m == 11) begin
                n_total++; if (mux_valid !== 1'b0) $display("FAIL sw_reset_end mux_valid got %b exp 0", mux_valid); else n_pass++;
            end
        end
        n_total++; if (ana_sw !== 4'b0100) $display("FAIL sw_run ana_sw got %b exp 0100", ana_sw); else n_pass++;
        n_total++; if (mux_valid !== 1'b1) $display("FAIL sw_run mux_valid got %b exp 1", mux_valid); else n_pass++;
        n_total++; if (slot_rst_n !== 4'b0100) $display("FAIL sw_run slot_rst_n got %b exp 0100", slot_rst_n); else n_pass++;
        n_total++; if (mux_sel !== 2'd2) $display("FAIL sw_run mux_sel got %0d exp 2", mux_sel); else n_pass++;
        n_total++; if (busy_cnt != 12) $display("FAIL sw_busy_cycles got %0d exp 12", busy_cnt); else n_pass++;
    endtask

    task automatic test_same_slot;
        do_switch(2'd1);
        n_total++; if (ana_sw !== 4'b0010) $display("FAIL same_pre ana_sw got %b exp 0010", ana_sw); else n_pass++;
        sel_req    = 2'd1;
        sel_strobe = 1'b1;
        tick();
        sel_strobe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_total++; if (busy !== 1'b0) $display("FAIL same_busy k=%0d got %b exp 0", k, busy); else n_pass++;
            n_total++; if (ana_sw !== 4'b0010) $display("FAIL same_ana_sw k=%0d got %b exp 0010", k, ana_sw); else n_pass++;
            n_total++; if (mux_valid !== 1'b1) $display("FAIL same_mux_valid k=%0d got %b exp 1", k, mux_valid); else n_pass++;
        end
    endtask

    task automatic test_retarget;
        do_switch(2'd0);
        n_total++; if (ana_sw !== 4'b0001) $display("FAIL rt_pre ana_sw got %b exp 0001", ana_sw); else n_pass++;
        sel_req    = 2'd2;
        sel_strobe = 1'b1;
        tick();
        for (int m = 1; m <= 25; m++) begin
            if (m == 3) begin
                sel_req    = 2'd3;
                sel_strobe = 1'b1;
            end else if (m == 10) begin
                sel_req    = 2'd1;
                sel_strobe = 1'b1;
            end else begin
                sel_strobe = 1'b0;
            end
            tick();
            n_total++; if ((ana_sw & ~slot_ena) !== 4'b0000) $display("FAIL rt_inv_ana m=%0d ana_sw %b slot_ena %b", m, ana_sw, slot_ena); else n_pass++;
            n_total++; if ((slot_rst_n & ~slot_ena) !== 4'b0000) $display("FAIL rt_inv_rst m=%0d slot_rst_n %b slot_ena %b", m, slot_rst_n, slot_ena); else n_pass++;
            n_total++; if ($countones(ana_sw) > 1) $display("FAIL rt_inv_onehot m=%0d ana_sw %b", m, ana_sw); else n_pass++;
            n_total++; if (slot_ena === 4'b0100) $display("FAIL rt_no_slot2 m=%0d slot_ena got %b exp not 0100", m, slot_ena); else n_pass++;
            if (m == 8) begin
                n_total++; if (slot_ena !== 4'b1000) $display("FAIL rt_reset3 slot_ena got %b exp 1000", slot_ena); else n_pass++;
                n_total++; if (cur_slot !== 2'd3) $display("FAIL rt_reset3 cur_slot got %0d exp 3", cur_slot); else n_pass++;
            end
            if (m == 12) begin
                n_total++; if (mux_valid !== 1'b1) $display("FAIL rt_run3 mux_valid got %b exp 1", mux_valid); else n_pass++;
                n_total++; if (ana_sw !== 4'b1000) $display("FAIL rt_run3 ana_sw got %b exp 1000", ana_sw); else n_pass++;
            end
            if (m == 13) begin
                n_total++; if (busy !== 1'b1) $display("FAIL rt_rebreak busy got %b exp 1", busy); else n_pass++;
                n_total++; if (ana_sw !== 4'b0000) $display("FAIL rt_rebreak ana_sw got %b exp 0000", ana_sw); else n_pass++;
            end
            if (m == 21) begin
                n_total++; if (slot_ena !== 4'b0010) $display("FAIL rt_reset1 slot_ena got %b exp 0010", slot_ena); else n_pass++;
            end
            if (m == 24) begin
                n_total++; if (mux_valid !== 1'b0) $display("FAIL rt_reset1_end mux_valid got %b exp 0", mux_valid); else n_pass++;
            end
        end
        sel_strobe = 1'b0;
        n_total++; if (ana_sw !== 4'b0010) $display("FAIL rt_run1 ana_sw got %b exp 0010", ana_sw); else n_pass++;
        n_total++; if (cur_slot !== 2'd1) $display("FAIL rt_run1 cur_slot got %0d exp 1", cur_slot); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rt_run1 busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_ena_drop;
        sel_req    = 2'd2;
        sel_strobe = 1'b1;
        tick();
        sel_strobe = 1'b0;
        repeat (9) tick();
        n_total++; if (slot_ena !== 4'b0100) $display("FAIL ena_pre_reset slot_ena got %b exp 0100", slot_ena); else n_pass++;
        // Disable and a request land on the same edge; the request must be lost.
        ena        = 1'b0;
        sel_req    = 2'd3;
        sel_strobe = 1'b1;
        tick();
        sel_strobe = 1'b0;
        n_total++; if (slot_ena !== 4'b0000) $display("FAIL ena_off slot_ena got %b exp 0000", slot_ena); else n_pass++;
        n_total++; if (slot_rst_n !== 4'b0000) $display("FAIL ena_off slot_rst_n got %b exp 0000", slot_rst_n); else n_pass++;
        n_total++; if (ana_sw !== 4'b0000) $display("FAIL ena_off ana_sw got %b exp 0000", ana_sw); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ena_off busy got %b exp 0", busy); else n_pass++;
        n_total++; if (mux_valid !== 1'b0) $display("FAIL ena_off mux_valid got %b exp 0", mux_valid); else n_pass++;
        n_total++; if (cur_slot !== 2'd2) $display("FAIL ena_off cur_slot got %0d exp 2", cur_slot); else n_pass++;
        tick();
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL ena_off_hold busy got %b exp 0", busy); else n_pass++;
        ena = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            tick();
            if (m == 13) begin
                n_total++; if (mux_valid !== 1'b0) $display("FAIL ena_up_early mux_valid got %b exp 0", mux_valid); else n_pass++;
            end
        end
        n_total++; if (mux_valid !== 1'b1) $display("FAIL ena_up_run mux_valid got %b exp 1", mux_valid); else n_pass++;
        n_total++; if (ana_sw !== 4'b0100) $display("FAIL ena_up_run ana_sw got %b exp 0100", ana_sw); else n_pass++;
        n_total++; if (cur_slot !== 2'd2) $display("FAIL ena_up_run cur_slot got %0d exp 2", cur_slot); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_switch(2'd3);
        n_total++; if (ana_sw !== 4'b1000) $display("FAIL ar_pre ana_sw got %b exp 1000", ana_sw); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (ana_sw !== 4'b0000) $display("FAIL ar_now ana_sw got %b exp 0000", ana_sw); else n_pass++;
        n_total++; if (slot_ena !== 4'b0000) $display("FAIL ar_now slot_ena got %b exp 0000", slot_ena); else n_pass++;
        n_total++; if (slot_rst_n !== 4'b0000) $display("FAIL ar_now slot_rst_n got %b exp 0000", slot_rst_n); else n_pass++;
        n_total++; if (mux_valid !== 1'b0) $display("FAIL ar_now mux_valid got %b exp 0", mux_valid); else n_pass++;
        n_total++; if (cur_slot !== 2'd0) $display("FAIL ar_now cur_slot got %0d exp 0", cur_slot); else n_pass++;
        n_total++; if (mux_sel !== 2'd0) $display("FAIL ar_now mux_sel got %0d exp 0", mux_sel); else n_pass++;
        #1;
        rst_n = 1'b1;
        repeat (14) tick();
        n_total++; if (ana_sw !== 4'b0001) $display("FAIL ar_up ana_sw got %b exp 0001", ana_sw); else n_pass++;
        n_total++; if (cur_slot !== 2'd0) $display("FAIL ar_up cur_slot got %0d exp 0", cur_slot); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_out_of_range();
        test_switch();
        test_same_slot();
        test_retarget();
        test_ena_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/grab_bag_slot_ctrl.md
# grab_bag_slot_ctrl

Slot controller for the grab-bag top level: decides which of NUM_SLOTS sub-designs owns the shared digital outputs and the analog pins, and sequences every hand-over. The sequence is break-before-make: all analog switches open and the output mux is disabled, then the new slot is held in reset, then it is released and connected. Sits directly under the tt_um top, driven by `ena` and by a select request decoded from `ui_in`.

## Interface

Parameters:
- NUM_SLOTS, 4: number of sub-designs; ≥2.
- SEL_W, 2: select width; must equal clog2(NUM_SLOTS).
- BREAK_CYCLES, 8: dead-time cycles with everything disconnected; ≥1.
- RESET_CYCLES, 4: cycles the incoming slot is enabled but held in reset; ≥1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; low forces OFF.
- sel_req  in  SEL_W  requested slot index.
- sel_strobe  in  1  one-cycle request qualifier for sel_req.
- slot_ena  out  NUM_SLOTS  one-hot/zero enable per slot.
- slot_rst_n  out  NUM_SLOTS  per-slot active-low reset.
- ana_sw  out  NUM_SLOTS  one-hot/zero analog switch enable.
- mux_sel  out  SEL_W  output-mux select; equals cur_slot.
- mux_valid  out  1  output mux enabled; when 0 the top forces uo_out/uio_oe to 0.
- cur_slot  out  SEL_W  slot currently owning (or being brought up on) the outputs.
- busy  out  1  high in BREAK and RESET.

## Operation

- States: OFF, BREAK, RESET, RUN. All outputs are registered and are a function of the registered state and cur_slot only, so there are no decode glitches on switch enables.
- Registers: state, cur_slot, tgt (pending target), cnt (down-counter sized for max(BREAK_CYCLES, RESET_CYCLES)).
- Valid request: ena=1, sel_strobe=1, sel_req<NUM_SLOTS. It updates tgt in any state. Out-of-range requests are ignored. All strobes are ignored while ena=0; tgt is retained.
- OFF:
  - Outputs: slot_ena=0, slot_rst_n=0, ana_sw=0, mux_valid=0, busy=0.
  - On ena=1 → BREAK.
- BREAK:
  - Outputs: as OFF, but busy=1.
  - After BREAK_CYCLES cycles → RESET; on that edge cur_slot←tgt (using tgt including any request sampled on that same edge).
- RESET:
  - Outputs: slot_ena=onehot(cur_slot), slot_rst_n=0, ana_sw=0, mux_valid=0, busy=1.
  - After RESET_CYCLES cycles → RUN.
- RUN:
  - Outputs: slot_ena=onehot(cur_slot), slot_rst_n=onehot(cur_slot), ana_sw=onehot(cur_slot), mux_valid=1, busy=0.
  - Non-selected slots stay enable=0, reset asserted.
- RUN exit: → BREAK on the edge where either condition holds:
  - a valid request has sel_req≠cur_slot, or
  - tgt≠cur_slot.
- A request equal to cur_slot in RUN causes no transition.
- Retargeting:
  - A request during BREAK changes the slot brought up, with no extra cycles.
  - A request during RESET completes the current bring-up, reaches RUN for exactly 1 cycle, then re-enters BREAK.
- ena=0 in any state → OFF on the next edge. The counter is discarded, and cur_slot and tgt are kept.
- Invariant: ana_sw and slot_rst_n for a slot are never high unless that slot's slot_ena is high. At most one ana_sw bit is set in any cycle.

## Timing

- Reset values: state=OFF, cur_slot=0, tgt=0, cnt=0, and all outputs 0 (mux_sel=0). The asynchronous rst_n assertion takes effect immediately, mid-sequence included.
- Request sampled at edge E0 in RUN:
  - BREAK outputs visible after E0.
  - RESET after E0+BREAK_CYCLES.
  - RUN after E0+BREAK_CYCLES+RESET_CYCLES, which is 12 cycles with defaults.
- Power-up: ena rises and is sampled at E0; RUN is reached after E0+1+BREAK_CYCLES+RESET_CYCLES (13 cycles with defaults).
- busy is high for exactly BREAK_CYCLES+RESET_CYCLES cycles per uninterrupted switch.
- Simultaneous ena=0 and a request on the same edge: OFF wins and the request is dropped.

## Test plan

- Reset values: hold rst_n=0 with ena=1 → all outputs 0, cur_slot=0. Release and keep ena=1 → RUN on slot 0 after 13 cycles; slot_ena=0001, ana_sw=0001, mux_valid=1.
- Switch 0→2 in RUN: sel_req=2 with a strobe at E0 → ana_sw=0000 after E0; slot_ena=0100 with slot_rst_n=0000 after E0+8; ana_sw=0100 and mux_valid=1 after E0+12; busy high for 12 cycles.
- Same-slot and out-of-range requests: in RUN on slot 1, a strobe with sel_req=1 → no output change; build with NUM_SLOTS=3, strobe sel_req=3 → ignored.
- Retarget: in RUN on slot 0, request 2, then request 3 during BREAK → RESET and RUN on slot 3 only. Request 1 during RESET → 1 RUN cycle on slot 3, then BREAK, then RUN on slot 1.
- ena=0 mid-RESET → OFF next cycle with all outputs 0. Re-assert ena → full 13-cycle bring-up on the retained cur_slot/tgt.
- Async reset mid-RUN on slot 3: pulse rst_n low between edges → outputs 0 immediately, before the next edge; cur_slot=0.
